seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one 4-bit binary-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a double-buffered digit store. A writer fills the shadow bank, then requests a commit. The commit takes effect only at a frame boundary, so a partially updated frame is never displayed.
- Sits between user logic and the shared decoder: drives the decoder's 4-bit input code and the active-low digit anode enables, with a blanking gap between digits to prevent ghosting.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; legal range 2..8.
- DIV, 50000: clock cycles per digit slot (blank plus drive).
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < DIV.

Ports:
- CLOCK_50  in  1  system clock.
- RST_n  in  1  asynchronous, active-low reset.
- WR_EN  in  1  shadow write strobe; sampled every cycle.
- WR_ADDR  in  3  shadow digit index.
- WR_DATA  in  4  binary code for that digit.
- COMMIT  in  1  single-cycle request to transfer shadow to active at the next frame boundary.
- PENDING  out  1  commit requested, not yet applied.
- CODE  out  4  code driven to the shared decoder.
- AN_n  out  NUM_DIGITS  digit enables, one-hot active-low.
- FRAME_START  out  1  one-cycle pulse at the first cycle of each frame.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset RST_n is asynchronous, active-low.
- Reset values: shadow and active banks all 0; CODE=0; AN_n all 1; PENDING=0; FRAME_START=0; slot counter cnt=0; digit index idx=0.
- Reset mid-operation: AN_n goes all 1 immediately on RST_n low, without waiting for a clock edge. Scanning restarts from idx=0, cnt=0 after release.
- Slot counter: cnt runs 0..DIV-1. On cnt==DIV-1, cnt wraps to 0 and idx advances, with idx NUM_DIGITS-1 wrapping to 0.
- Slot FSM, derived from cnt (all outputs registered):
  - BLANK (cnt < BLANK_CYC): AN_n all 1.
  - DRIVE (cnt >= BLANK_CYC): AN_n[idx]=0, all other bits 1.
- CODE: registered equal to active[idx]. It updates on the same edge idx advances, so CODE is stable for the whole BLANK window before its anode turns on.
- Writes: when WR_EN=1 and WR_ADDR < NUM_DIGITS, shadow[WR_ADDR] <= WR_DATA. Writes with WR_ADDR >= NUM_DIGITS are ignored. Writes never touch the active bank.
- Frame boundary: the cycle where cnt==DIV-1 and idx==NUM_DIGITS-1.
  - If PENDING=1 on that edge, active <= shadow. The copy uses shadow contents before any same-cycle write.
- PENDING next value = COMMIT | (PENDING & ~boundary).
  - COMMIT on the boundary cycle while PENDING=0: not applied this frame; PENDING=1, applied at the next boundary.
  - COMMIT on the boundary cycle while PENDING=1: copy happens and PENDING stays 1. The new commit applies at the next boundary.
  - Repeated COMMITs while pending merge into one.
- FRAME_START: 1 for exactly the cycle where cnt==0 and idx==0, except the first cycle after reset release.
- Commit latency: the new value for digit k first appears on CODE at the start of digit k's slot in the frame following the boundary.

Test Plan (NUM_DIGITS=4, DIV=8, BLANK_CYC=2):
- Reset and scan:
  - During reset: AN_n=1111, CODE=0, PENDING=0.
  - After release: cycles 0-1 AN_n=1111; 2-7 AN_n=1110; 8-9 AN_n=1111; 10-15 AN_n=1101; and so on. FRAME_START at cycle 32.
- Commit:
  - Write 1,2,3,4 to addresses 0..3, then COMMIT at cycle 5 -> PENDING=1 through cycle 31, 0 from cycle 32.
  - CODE=1 during cycles 32-39, 2 during 40-47, 3 during 48-55, 4 during 56-63.
- No commit: write 9 to address 2, no COMMIT -> CODE stays 0 in every slot for 3 frames; PENDING=0.
- Coincident commit:
  - COMMIT at boundary cycle 31 with PENDING=0 -> PENDING stays 1 through cycle 63; active updates at cycle 63 boundary.
  - Write on cycle 31 is excluded from any copy made at that boundary.
- Illegal address: WR_EN with WR_ADDR=5, data 7, then COMMIT -> all active digits unchanged.
- Async reset: RST_n low at cycle 13 during DRIVE -> AN_n=1111 before the next edge; PENDING=0 and both banks clear.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for common-anode 7-segment digits sharing one decoder.
// A double-buffered digit store is committed to the display only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_n,
  input  logic                  WR_EN,
  input  logic [2:0]            WR_ADDR,
  input  logic [3:0]            WR_DATA,
  input  logic                  COMMIT,
  output logic                  PENDING,
  output logic [3:0]            CODE,
  output logic [NUM_DIGITS-1:0] AN_n,
  output logic                  FRAME_START
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            shadow_q [NUM_DIGITS];
  logic [3:0]            shadow_d [NUM_DIGITS];
  logic [3:0]            active_q [NUM_DIGITS];
  logic [3:0]            active_d [NUM_DIGITS];
  logic                  pend_q, pend_d;
  logic [3:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;
  logic                  slot_end, boundary;
  logic [0:0]            st_d;

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    boundary = slot_end && (idx_q == IDX_MAX);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);

    // Copy sees the shadow as it was before this cycle's write
    active_d = active_q;
    if (boundary && pend_q)
      active_d = shadow_q;

    shadow_d = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (WR_EN && WR_ADDR == 3'(i))
        shadow_d[i] = WR_DATA;

    pend_d = COMMIT | (pend_q & ~boundary);

    // Outputs are registered from next-state so they align with cnt/idx
    st_d = (cnt_d < BLANK_C) ? ST_BLANK : ST_DRIVE;
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (st_d == ST_DRIVE && idx_d == IW'(i))
        an_d[i] = 1'b0;

    code_d = active_d[idx_d];
    fs_d   = boundary;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      code_q <= '0;
      an_q   <= '1;
      fs_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign PENDING     = pend_q;
  assign CODE        = code_q;
  assign AN_n        = an_q;
  assign FRAME_START = fs_q;

endmodule
